// File: rtl/led_pkg.sv
// Shared state encodings and owner codes for the LED frame arbiter,
// its scan driver and the top level.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT_A = 2'b01,
        ST_GRANT_B = 2'b10
    } state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_A    = 2'b01;
    localparam logic [1:0] OWNER_B    = 2'b10;

endpackage

// File: rtl/led_hold_timer.sv
// Grant dwell timer: loads HOLD_CYCLES-1 on i_load, counts down to 0 and saturates.
// o_zero is a direct decode of the count register; no backpressure.
module led_hold_timer #(
    parameter int unsigned HOLD_CYCLES = 1200000
) (
    input  logic clk12MHz,
    input  logic rst_n,
    input  logic i_load,
    output logic o_zero
);

    logic [31:0] r_cnt;

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 32'd0;
        end else if (i_load) begin
            r_cnt <= 32'(HOLD_CYCLES - 1);
        end else if (r_cnt != 32'd0) begin
            r_cnt <= r_cnt - 32'd1;
        end
    end

    assign o_zero = (r_cnt == 32'd0);

endmodule

// File: rtl/led_frame_arbiter.sv
// Two-requester arbiter for the LED matrix with minimum grant dwell and fair alternation.
// Outputs registered, one cycle after the deciding edge; requesters wait by holding req high.
module led_frame_arbiter
    import led_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1200000
) (
    input  logic        clk12MHz,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic [31:0] frame_a,
    output logic        ack_a,
    input  logic        req_b,
    input  logic [31:0] frame_b,
    output logic        ack_b,
    output logic [7:0]  l1,
    output logic [7:0]  l2,
    output logic [7:0]  l3,
    output logic [7:0]  l4,
    output logic [1:0]  owner
);

    state_t      r_state;
    logic [1:0]  r_last_served;
    logic [1:0]  r_owner;
    logic [31:0] r_rows;
    logic        r_ack_a;
    logic        r_ack_b;
    logic        w_zero;
    logic        w_grant_a;
    logic        w_grant_b;

    // Grant decisions feed both the FSM and the dwell timer load.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_a && (!req_b || r_last_served == OWNER_B)) begin
                    w_grant_a = 1'b1;
                end else if (req_b) begin
                    w_grant_b = 1'b1;
                end
            end
            ST_GRANT_A: w_grant_b = w_zero && req_b;
            ST_GRANT_B: w_grant_a = w_zero && req_a;
            default: ;
        endcase
    end

    led_hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk12MHz (clk12MHz),
        .rst_n    (rst_n),
        .i_load   (w_grant_a | w_grant_b),
        .o_zero   (w_zero)
    );

    always_ff @(posedge clk12MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_last_served <= OWNER_B;
            r_owner       <= OWNER_NONE;
            r_rows        <= 32'd0;
            r_ack_a       <= 1'b0;
            r_ack_b       <= 1'b0;
        end else begin
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            if (w_grant_a) begin
                r_state       <= ST_GRANT_A;
                r_rows        <= frame_a;
                r_ack_a       <= 1'b1;
                r_owner       <= OWNER_A;
                r_last_served <= OWNER_A;
            end else if (w_grant_b) begin
                r_state       <= ST_GRANT_B;
                r_rows        <= frame_b;
                r_ack_b       <= 1'b1;
                r_owner       <= OWNER_B;
                r_last_served <= OWNER_B;
            end else begin
                // Owner keeps refreshing rows while it requests; a dropped req freezes them.
                case (r_state)
                    ST_GRANT_A: begin
                        if (req_a) begin
                            r_rows <= frame_a;
                        end else if (w_zero) begin
                            r_state <= ST_IDLE;
                            r_rows  <= 32'd0;
                            r_owner <= OWNER_NONE;
                        end
                    end
                    ST_GRANT_B: begin
                        if (req_b) begin
                            r_rows <= frame_b;
                        end else if (w_zero) begin
                            r_state <= ST_IDLE;
                            r_rows  <= 32'd0;
                            r_owner <= OWNER_NONE;
                        end
                    end
                    ST_IDLE: ;
                    default: begin
                        r_state <= ST_IDLE;
                        r_rows  <= 32'd0;
                        r_owner <= OWNER_NONE;
                    end
                endcase
            end
        end
    end

    assign ack_a = r_ack_a;
    assign ack_b = r_ack_b;
    assign owner = r_owner;
    assign l1    = r_rows[7:0];
    assign l2    = r_rows[15:8];
    assign l3    = r_rows[23:16];
    assign l4    = r_rows[31:24];

endmodule
